// File: rtl/store_buffer_pkg.sv
// Store buffer shared types and defaults.
// Entry layout and word-granular address compare.
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic logic sb_word_match(
    input logic [SB_AW-1:0] a,
    input logic [SB_AW-1:0] b
  );
    return a[SB_AW-1:2] == b[SB_AW-1:2];
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Drain port from the store buffer to data memory.
// Master presents the head entry; slave accepts with mem_ready.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
);
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/store_buffer_fifo.sv
// Store buffer storage: entry array, wrap pointers, count.
// Pointers carry an extra lap bit to tell full from empty.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  sb_entry_t push_entry,
  input  logic      pop,
  output sb_entry_t head,
  output sb_entry_t entries [DEPTH],
  output logic [IW-1:0] rd_idx,
  output logic [PW-1:0] count,
  output logic      full,
  output logic      empty
);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  sb_entry_t     mem_q [DEPTH];
  sb_entry_t     mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q ^ rd_ptr_q)
               == {1'b1, {IW{1'b0}}};
  assign count = wr_ptr_q - rd_ptr_q;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign rd_idx  = rd_ptr_q[IW-1:0];
  assign head    = mem_q[rd_idx];
  assign entries = mem_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[IW-1:0]] = push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/store_buffer.sv
// Zero-stall store buffer between core and data memory.
// Drains in order, forwards youngest match to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic [PW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err_misaligned,
  store_buffer_if.master mem
);
  sb_entry_t     head;
  sb_entry_t     push_entry;
  sb_entry_t     entries [DEPTH];
  logic [IW-1:0] rd_idx;
  logic          enq;
  logic          deq;
  logic          err_q, err_d;

  assign stall = memwrite & full;
  assign enq   = memwrite & ~full;
  assign deq   = ~empty & mem.mem_ready;

  assign push_entry.addr = dataadr;
  assign push_entry.data = writedata;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (enq),
    .push_entry (push_entry),
    .pop        (deq),
    .head       (head),
    .entries    (entries),
    .rd_idx     (rd_idx),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign mem.mem_valid = ~empty;
  assign mem.mem_addr  = head.addr;
  assign mem.mem_wdata = head.data;

  // Scan oldest to youngest so the last hit wins.
  always_comb begin
    logic [IW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_idx + IW'(i);
      if (PW'(i) < count &&
          sb_word_match(entries[idx].addr, dataadr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  always_comb begin
    err_d = err_q | (enq & (|dataadr[1:0]));
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_misaligned = err_q;
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Responder for the processor's data-store port (memwrite, dataadr, writedata).
- Accepts stores from the single-cycle core in 0 stall cycles while space remains.
- Buffers them in a small FIFO and drains them to the data memory over a valid/ready handshake.
- Forwards buffered data to loads so the core never reads stale memory. Sits between the processor's datapath and data memory inside top.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- memwrite  input  1  core store request this cycle.
- dataadr  input  AW  core store/load byte address.
- writedata  input  DW  core store data.
- stall  output  1  core must hold its current instruction (PC not updated).
- fwd_hit  output  1  buffered store matches dataadr (word compare).
- fwd_data  output  DW  data of the youngest matching buffered store.
- mem_valid  output  1  head entry presented to data memory.
- mem_addr  output  AW  head entry address.
- mem_wdata  output  DW  head entry data.
- mem_ready  input  1  data memory accepts head this cycle.
- count  output  $clog2(DEPTH)+1  occupied entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- err_misaligned  output  1  sticky: a store with dataadr[1:0]!=0 was seen.

Behaviour:
- Reset (synchronous, active-high): rd/wr pointers=0, count=0, empty=1, full=0, mem_valid=0, fwd_hit=0, err_misaligned=0. Buffered entries are discarded; a transfer in progress is abandoned (mem_valid drops the cycle after reset is sampled).
- Enqueue: memwrite=1 and full=0 → entry {dataadr, writedata} written at wr_ptr on the rising edge; wr_ptr increments modulo DEPTH.
- stall = memwrite & full, combinational. No enqueue while stalled, including when mem_ready=1 in the same cycle; the store is accepted the following cycle. There is deliberately no mem_ready→stall path.
- Dequeue: mem_valid & mem_ready → rd_ptr increments modulo DEPTH.
- mem_valid = !empty. mem_addr and mem_wdata come from the head entry register.
- mem_addr and mem_wdata hold stable while mem_valid=1 and mem_ready=0.
- Count rules:
  - Simultaneous enqueue and dequeue (not full) → count unchanged; both pointers advance.
  - Enqueue only → +1.
  - Dequeue only → −1.
  - Count never exceeds DEPTH and never underflows.
- Latency: a store accepted in cycle N shows mem_valid=1 in cycle N+1 if the buffer was empty.
- Forwarding:
  - Combinational compare of dataadr[AW-1:2] against all valid entries.
  - fwd_hit=1 if any match; fwd_data is the youngest match, i.e. nearest to wr_ptr.
  - An entry being dequeued this cycle still forwards this cycle.
  - The store being enqueued this cycle does not forward to itself.
  - fwd_hit=0 when empty.
- Misaligned stores: the address is stored and forwarded as given. err_misaligned sets on the rising edge after acceptance and stays set until reset.
- Wrap-around: pointers carry one extra bit; full/empty are derived from pointer equality plus the MSB difference.

Decomposition:
- Package store_buffer_pkg holds:
  - localparam defaults SB_DEPTH=4, SB_AW=32, SB_DW=32;
  - typedef sb_entry_t {addr, data};
  - function sb_word_match(a,b) comparing [AW-1:2].
- One sub-module, store_buffer_fifo: storage array, pointers, count, full/empty.
- Stall, forwarding compare and error flag stay in store_buffer.

Test Plan:
- Reset mid-operation: load 3 entries, assert reset one cycle while mem_ready=0 → next cycle count=0, empty=1, mem_valid=0, err_misaligned=0; a new store to 80 afterwards drains normally.
- Single store, drain: memwrite=1, dataadr=84, writedata=7 with mem_ready=1 → next cycle mem_valid=1, mem_addr=84, mem_wdata=7; one cycle later empty=1.
- Fill and stall: mem_ready=0, stores to 0,4,8,12 (data 1..4), then a 5th store to 16 → full=1, stall=1, count=4. Raise mem_ready for one cycle → count=3, stall=0, and the store to 16 is accepted the next cycle.
- Forwarding youngest: stores 80←5 then 80←9, mem_ready=0, dataadr=80 (no memwrite) → fwd_hit=1, fwd_data=9. dataadr=83 → hit, data 9. dataadr=84 → fwd_hit=0.
- Simultaneous enqueue/dequeue with wrap: DEPTH=4, count=2, mem_ready=1 and a store every cycle for 10 cycles → count stays 2. Drain order equals issue order across pointer wrap, checked against a reference queue.
- Misaligned: store to 86 → err_misaligned=1 on the next cycle and stays 1 through 20 further aligned stores; entry drains with mem_addr=86.
